mcycle_sequencer: RTL and testbench



---
 rtl/mcycle_sequencer_if.sv | 25 ++
 rtl/mcycle_sequencer.sv | 124 ++++++++++++
 tb/tb_mcycle_sequencer.sv | 210 +++++++++++++++++++++
 3 files changed

// File: rtl/mcycle_sequencer_if.sv
// Execute-stage <-> multi-cycle multiply/divide handshake bundle.
// The pipeline side is the master; the sequencer is the slave.
interface mcycle_sequencer_if #(
    parameter int WIDTH = 32
);
    logic             Start;
    logic             MCycleOp;
    logic             Abort;
    logic [WIDTH-1:0] Operand1;
    logic [WIDTH-1:0] Operand2;
    logic [WIDTH-1:0] Result1;
    logic [WIDTH-1:0] Result2;
    logic             Busy;
    logic             Done;

    modport master (
        output Start, MCycleOp, Abort, Operand1, Operand2,
        input  Result1, Result2, Busy, Done
    );

    modport slave (
        input  Start, MCycleOp, Abort, Operand1, Operand2,
        output Result1, Result2, Busy, Done
    );
endinterface

// File: rtl/mcycle_sequencer.sv
// Iterative shift/add multiplier and restoring divider for the Execute stage.
// One iteration per clock; results are published for a single Done cycle.
module mcycle_sequencer #(
    parameter int WIDTH = 32
) (
    input  logic              CLK,
    input  logic              Reset,
    mcycle_sequencer_if.slave bus
);
    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {IDLE, COMPUTE, DONE} state_e;

    state_e           state_q, state_d;
    logic [CW-1:0]    count_q, count_d;
    logic             op_q, op_d;
    // Multiplicand for multiply, divisor for divide.
    logic [WIDTH-1:0] opnd_q, opnd_d;
    // hi: product high part (with carry) or partial remainder R.
    // lo: multiplier shift register or quotient/dividend Q.
    logic [WIDTH:0]   hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;
    logic [WIDTH-1:0] res1_q, res1_d;
    logic [WIDTH-1:0] res2_q, res2_d;

    logic [WIDTH:0]   mul_sum;
    logic [WIDTH:0]   div_sh;
    logic [WIDTH:0]   div_diff;
    logic [WIDTH:0]   hi_nx;
    logic [WIDTH-1:0] lo_nx;
    logic             last;

    // One datapath iteration for whichever operation is latched.
    always_comb begin
        mul_sum  = hi_q + (lo_q[0] ? {1'b0, opnd_q} : '0);
        div_sh   = {hi_q[WIDTH-1:0], lo_q[WIDTH-1]};
        div_diff = div_sh - {1'b0, opnd_q};
        hi_nx    = {1'b0, mul_sum[WIDTH:1]};
        lo_nx    = {mul_sum[0], lo_q[WIDTH-1:1]};
        if (op_q) begin
            if (div_sh >= {1'b0, opnd_q}) begin
                hi_nx = div_diff;
                lo_nx = {lo_q[WIDTH-2:0], 1'b1};
            end else begin
                hi_nx = div_sh;
                lo_nx = {lo_q[WIDTH-2:0], 1'b0};
            end
        end
    end

    assign last = (count_q == CW'(WIDTH - 1));

    always_comb begin
        state_d = state_q;
        count_d = count_q;
        op_d    = op_q;
        opnd_d  = opnd_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        res1_d  = res1_q;
        res2_d  = res2_q;
        unique case (state_q)
            IDLE: begin
                if (bus.Start && !bus.Abort) begin
                    op_d    = bus.MCycleOp;
                    opnd_d  = bus.MCycleOp ? bus.Operand2 : bus.Operand1;
                    lo_d    = bus.MCycleOp ? bus.Operand1 : bus.Operand2;
                    hi_d    = '0;
                    count_d = '0;
                    state_d = COMPUTE;
                end
            end
            COMPUTE: begin
                if (bus.Abort) begin
                    state_d = IDLE;
                end else begin
                    hi_d    = hi_nx;
                    lo_d    = lo_nx;
                    count_d = count_q + 1'b1;
                    if (last) begin
                        // Product {hi,lo} and {R,Q} share the same result mapping.
                        res1_d  = lo_nx;
                        res2_d  = hi_nx[WIDTH-1:0];
                        state_d = DONE;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            state_q <= IDLE;
            count_q <= '0;
            op_q    <= 1'b0;
            opnd_q  <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            res1_q  <= '0;
            res2_q  <= '0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            op_q    <= op_d;
            opnd_q  <= opnd_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            res1_q  <= res1_d;
            res2_q  <= res2_d;
        end
    end

    // Busy follows Start combinationally in IDLE so the stall starts in the request cycle.
    assign bus.Busy    = (state_q == COMPUTE) || ((state_q == IDLE) && bus.Start);
    assign bus.Done    = (state_q == DONE);
    assign bus.Result1 = res1_q;
    assign bus.Result2 = res2_q;
endmodule

// File: tb/tb_mcycle_sequencer.sv
// Self-checking bench for mcycle_sequencer: directed vector table, abort/reset
// sequences, and random operations checked against plain-arithmetic results.
module tb_mcycle_sequencer;
    localparam int W = 32;

    logic CLK = 1'b0;
    logic Reset;
    always #5 CLK = ~CLK;

    mcycle_sequencer_if #(.WIDTH(W)) bus ();
    mcycle_sequencer #(.WIDTH(W)) dut (.CLK(CLK), .Reset(Reset), .bus(bus));

    typedef struct {
        logic         op;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] r1;
        logic [W-1:0] r2;
        bit           hold;
    } vec_t;

    vec_t         vecs [10];
    int           n_tests = 0;
    int           n_fail  = 0;
    logic [W-1:0] last_r1 = '0;
    logic [W-1:0] last_r2 = '0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Entered 1 time unit after a rising edge with the sequencer in IDLE.
    task automatic do_op(input string tag, input logic op, input logic [W-1:0] a,
                         input logic [W-1:0] b, input logic [W-1:0] e1,
                         input logic [W-1:0] e2, input bit hold);
        int           busy_n;
        int           extra_done;
        bit           got;
        bit           stable;
        logic [W-1:0] p1;
        logic [W-1:0] p2;
        busy_n     = 0;
        extra_done = 0;
        got        = 0;
        stable     = 1;
        p1         = last_r1;
        p2         = last_r2;
        bus.Start    = 1'b1;
        bus.MCycleOp = op;
        bus.Operand1 = a;
        bus.Operand2 = b;
        bus.Abort    = 1'b0;
        for (int c = 0; c < W + 8 && !got; c++) begin
            #1;
            if (bus.Done) begin
                got = 1;
                chk({tag, " result1"}, bus.Result1, e1);
                chk({tag, " result2"}, bus.Result2, e2);
                chk({tag, " busy_in_done"}, bus.Busy, 1'b0);
                if (!hold) bus.Start = 1'b0;
            end else begin
                if (bus.Busy) busy_n++;
                if (bus.Result1 !== p1 || bus.Result2 !== p2) stable = 0;
            end
            @(posedge CLK);
            #1;
        end
        chk({tag, " done_seen"}, got, 1'b1);
        chk({tag, " busy_cycles"}, busy_n, W + 1);
        chk({tag, " results_held"}, stable, 1'b1);
        last_r1 = e1;
        last_r2 = e2;
        if (hold) begin
            bus.Start = 1'b0;
            for (int c = 0; c < 4; c++) begin
                #1;
                if (bus.Done || bus.Busy) extra_done++;
                @(posedge CLK);
                #1;
            end
            chk({tag, " no_restart"}, extra_done, 0);
        end
    endtask

    initial begin
        logic [63:0]  prod;
        logic [W-1:0] ra, rb, e1, e2;
        logic         rop;

        vecs[0] = '{1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, 32'hFFFF_FFFE, 1'b1};
        vecs[1] = '{1'b1, 32'd100,       32'd7,         32'd14,        32'd2,         1'b0};
        vecs[2] = '{1'b0, 32'h0001_0000, 32'h0001_0000, 32'h0000_0000, 32'h0000_0001, 1'b0};
        vecs[3] = '{1'b1, 32'h1234_5678, 32'h0,         32'hFFFF_FFFF, 32'h1234_5678, 1'b0};
        vecs[4] = '{1'b0, 32'd3,         32'd5,         32'd15,        32'd0,         1'b0};
        vecs[5] = '{1'b1, 32'd15,        32'd4,         32'd3,         32'd3,         1'b0};
        vecs[6] = '{1'b0, 32'h0,         32'hFFFF_FFFF, 32'h0,         32'h0,         1'b0};
        vecs[7] = '{1'b1, 32'h0,         32'd5,         32'h0,         32'h0,         1'b0};
        vecs[8] = '{1'b1, 32'hFFFF_FFFF, 32'd1,         32'hFFFF_FFFF, 32'h0,         1'b0};
        vecs[9] = '{1'b1, 32'd5,         32'hFFFF_FFFF, 32'h0,         32'd5,         1'b0};

        Reset        = 1'b1;
        bus.Start    = 1'b0;
        bus.MCycleOp = 1'b0;
        bus.Abort    = 1'b0;
        bus.Operand1 = '0;
        bus.Operand2 = '0;
        #2;
        chk("reset result1", bus.Result1, 0);
        chk("reset result2", bus.Result2, 0);
        chk("reset busy", bus.Busy, 0);
        chk("reset done", bus.Done, 0);
        repeat (2) @(posedge CLK);
        #1;
        Reset = 1'b0;

        foreach (vecs[i])
            do_op($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b,
                  vecs[i].r1, vecs[i].r2, vecs[i].hold);

        // Abort a divide at iteration 10.
        bus.Start    = 1'b1;
        bus.MCycleOp = 1'b1;
        bus.Operand1 = 32'd50;
        bus.Operand2 = 32'd5;
        @(posedge CLK);
        #1;
        repeat (10) begin
            @(posedge CLK);
            #1;
        end
        bus.Abort = 1'b1;
        #1;
        chk("abort busy_during", bus.Busy, 1'b1);
        @(posedge CLK);
        #1;
        bus.Abort = 1'b0;
        bus.Start = 1'b0;
        #1;
        chk("abort busy_after", bus.Busy, 1'b0);
        chk("abort done_after", bus.Done, 1'b0);
        chk("abort result1_kept", bus.Result1, last_r1);
        chk("abort result2_kept", bus.Result2, last_r2);
        @(posedge CLK);
        #1;
        chk("abort no_late_done", bus.Done, 1'b0);
        do_op("after_abort", 1'b1, 32'd50, 32'd5, 32'd10, 32'd0, 1'b0);

        // Asynchronous reset in the middle of a multiply.
        bus.Start    = 1'b1;
        bus.MCycleOp = 1'b0;
        bus.Operand1 = 32'd7;
        bus.Operand2 = 32'd9;
        @(posedge CLK);
        #1;
        repeat (5) begin
            @(posedge CLK);
            #1;
        end
        bus.Start = 1'b0;
        Reset     = 1'b1;
        #1;
        chk("midreset result1", bus.Result1, 0);
        chk("midreset result2", bus.Result2, 0);
        chk("midreset busy", bus.Busy, 0);
        chk("midreset done", bus.Done, 0);
        #1;
        Reset   = 1'b0;
        last_r1 = '0;
        last_r2 = '0;
        @(posedge CLK);
        #1;
        chk("midreset no_done", bus.Done, 0);
        do_op("after_reset", 1'b0, 32'd2, 32'd2, 32'd4, 32'd0, 1'b0);

        // Random operations against plain arithmetic.
        for (int n = 0; n < 40; n++) begin
            rop = 1'($urandom_range(0, 1));
            case ($urandom_range(0, 4))
                0:       ra = '0;
                1:       ra = '1;
                default: ra = $urandom;
            endcase
            case ($urandom_range(0, 5))
                0:       rb = '0;
                1:       rb = '1;
                2:       rb = W'($urandom_range(1, 300));
                default: rb = $urandom;
            endcase
            if (!rop) begin
                prod = 64'(ra) * 64'(rb);
                e1   = prod[W-1:0];
                e2   = prod[2*W-1:W];
            end else if (rb == '0) begin
                e1 = '1;
                e2 = ra;
            end else begin
                e1 = ra / rb;
                e2 = ra % rb;
            end
            do_op($sformatf("rand%0d op%0d %0h,%0h", n, rop, ra, rb), rop, ra, rb, e1, e2, 1'b0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
